uart_param: RTL and testbench
=============================

# uart_param

Parametrised full-duplex UART core replacing the fixed 8N1, fixed-baud receiver/transmitter. Data width, stop-bit count and oversampling ratio are compile-time parameters; the baud divisor is a run-time input; parity is an optional build feature. It sits between the board serial pins and the byte-level control logic. Framing and parity errors are reported per received character, and the transmit side uses a valid/ready handshake.

## Interface
- CLK_DIV_W, 16: width of the run-time baud divisor.
- DATA_BITS, 8: data bits per character, legal range 5..9.
- STOP_BITS, 1: stop bits transmitted, 1 or 2. The receiver always checks only the first stop bit.
- OVERSAMPLE, 16: ticks per bit, even, range 4..16.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Effective only with UART_PARITY_EN.

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- baud_div  in  CLK_DIV_W  tick period minus 1, in clk cycles; must be held stable while busy
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output, idles high
- tx_data  in  DATA_BITS  character to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter can accept a character
- rx_data  out  DATA_BITS  last received character
- rx_valid  out  1  one-cycle pulse per received character
- rx_frame_err  out  1  qualified by rx_valid; stop bit sampled low
- rx_parity_err  out  1  qualified by rx_valid; parity mismatch
- is_receiving  out  1  rx FSM not in IDLE
- is_transmitting  out  1  tx FSM not in IDLE

## Operation
- Reset values:
  - tx=1, tx_ready=0 during rst, 1 from the first cycle after rst deasserts.
  - rx_data=0; rx_valid, rx_frame_err, rx_parity_err, is_receiving and is_transmitting all 0.
  - Both FSMs return to IDLE. A reset mid-frame aborts the frame with no rx_valid pulse, and tx returns high immediately.
- Tick generator: a down-counter reloading baud_div issues a one-cycle tick at 0, i.e. every baud_div+1 clocks. One bit equals OVERSAMPLE ticks. Each direction owns a tick generator, which is restarted on frame start so that bit edges align.
- rx is first passed through a 2-flop synchroniser, and every rx decision uses the synchronised value.
- RX FSM states and transitions:
  - IDLE: a low synchronised rx restarts the tick generator and moves to START.
  - START: after OVERSAMPLE/2 ticks, rx still low moves to DATA; rx high is treated as a glitch and returns to IDLE.
  - DATA: each bit is sampled every OVERSAMPLE ticks, LSB first, DATA_BITS times. The FSM then moves to PARITY if enabled, otherwise to STOP.
  - PARITY: one sample, compared against the XOR of the data bits (inverted when PARITY_ODD=1).
  - STOP: one sample. rx high gives rx_valid with frame_err=0 and returns to IDLE. rx low gives rx_valid with frame_err=1 and moves to BREAK.
  - BREAK: waits for rx high, then returns to IDLE; no further pulses are issued.
- rx_data and both error flags update in the rx_valid cycle and hold until the next rx_valid.
- There is no receive buffer. The consumer must capture rx_data within one character time.
- TX FSM states and transitions:
  - IDLE: tx_ready=1. On tx_valid&&tx_ready the character is captured, tx_ready goes 0 and the FSM moves to START.
  - START, DATA (LSB first), PARITY (if enabled) and STOP each last OVERSAMPLE ticks per bit. STOP lasts STOP_BITS bits, then the FSM returns to IDLE.
  - tx_valid is ignored while tx_ready=0, and tx_data may change after acceptance.
- RX and TX are fully independent. Simultaneous activity has no interaction.

## Timing
- TX: tx falls 1 cycle after the accepting edge. tx_ready rises in the cycle after the final stop bit completes, so back-to-back characters have no idle gap.
- RX: the centre-of-bit sample lags the line by 2 synchroniser cycles plus at most 1 cycle of edge detection. rx_valid asserts 1 cycle after the stop-bit sample tick.
- A frame occupies (1 + DATA_BITS + P + STOP_BITS) × OVERSAMPLE × (baud_div+1) clocks, where P is 1 if parity is enabled, else 0.
- Counter widths: the tick counter is CLK_DIV_W bits and the oversample counter is $clog2(OVERSAMPLE) bits. The tick counter wraps only via reload, never by underflow.

## Configuration
- UART_PARITY_EN defined: a parity bit is inserted after the data bits on TX and checked on RX, with polarity set by PARITY_ODD.
- UART_PARITY_EN undefined: there is no parity bit, the PARITY states are unreachable, and rx_parity_err is tied to 0.

## Structure
- Package uart_param_pkg holds the RX and TX state enums and the constants for the legal DATA_BITS and OVERSAMPLE ranges. Elaboration checks on parameter legality also belong in the package.
- One sub-module, uart_tick_gen (clk, rst, restart, div → tick), is instantiated twice: once for RX and once for TX.

## Test plan
- DATA_BITS=8, no parity, baud_div=0, OVERSAMPLE=16:
  - Send 0xA5: tx is low for 16 cycles, then carries 1,0,1,0,0,1,0,1 at 16 cycles each, then is high for 16 cycles; tx_ready returns 1 after 160 cycles.
  - Loop tx back to rx and send 0x00, 0xFF, 0x3C back-to-back: exactly three rx_valid pulses with matching rx_data and both error flags 0.
- Drive a 4-cycle low glitch on rx: no rx_valid, and is_receiving returns to 0.
- Drive a frame with the stop bit held low, then 20 bit-times low: one rx_valid with frame_err=1, then no further pulses until rx goes high.
- UART_PARITY_EN, PARITY_ODD=0, send 0x07: the parity bit is 1. Inject 0x07 with the parity bit 0: rx_parity_err=1.
- Assert rst mid-TX and mid-RX: next cycle tx=1, tx_ready=0 while rst, no rx_valid; a fresh 0x55 is then received correctly.

Source files
------------

// File: rtl/uart_param_pkg.sv
// uart_param_pkg: shared types, legal parameter ranges and the parameter
// legality check for the parametrised UART core.
package uart_param_pkg;

   // Legal ranges for the compile-time configuration.
   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 9;
   localparam int OVERSAMPLE_MIN = 4;
   localparam int OVERSAMPLE_MAX = 16;
   localparam int STOP_BITS_MIN  = 1;
   localparam int STOP_BITS_MAX  = 2;

   // Bit counter width: large enough for DATA_BITS_MAX-1 and STOP_BITS_MAX-1.
   localparam int BIT_CNT_W = 4;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   // Elaboration-time legality check used by the top level.
   function automatic bit params_legal(input int data_bits,
                                       input int stop_bits,
                                       input int oversample,
                                       input int parity_odd);
      return (data_bits  >= DATA_BITS_MIN)  && (data_bits  <= DATA_BITS_MAX)  &&
             (stop_bits  >= STOP_BITS_MIN)  && (stop_bits  <= STOP_BITS_MAX)  &&
             (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
             ((oversample % 2) == 0) &&
             ((parity_odd == 0) || (parity_odd == 1));
   endfunction

endpackage

// File: rtl/uart_param_if.sv
// uart_param_if: byte-level side of the UART. The slave modport is the UART
// core; the master modport is the control logic that sends and receives.
interface uart_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_frame_err;
   logic                 rx_parity_err;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid,
      input  rx_frame_err,
      input  rx_parity_err
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid,
      output rx_frame_err,
      output rx_parity_err
   );
endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: oversample tick generator. A down-counter reloads from div
// and issues a one-cycle tick when it reaches zero, i.e. every div+1 clocks.
// Holding restart keeps the counter loaded so the first tick after release
// arrives a full period later, aligning bit edges with the frame start.
module uart_tick_gen #(
   parameter int CLK_DIV_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 restart,
   input  logic [CLK_DIV_W-1:0] div,
   output logic                 tick
);

   logic [CLK_DIV_W-1:0] count;

   // Count down to zero, reload on restart or after each tick.
   always_ff @(posedge clk) begin
      // NOTE: flops use non-blocking assignments so every register in the
      // design samples pre-edge values regardless of block ordering.
      if (rst || restart) begin
         count <= div;
      end else if (count == '0) begin
         count <= div;
      end else begin
         count <= count - 1'b1;
      end
   end

   assign tick = (count == '0) && !restart;

endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART core.
// Data width, stop bits and oversampling are compile-time parameters; the
// baud divisor is a run-time input. Define UART_PARITY_EN to insert a parity
// bit on TX and check it on RX (polarity from PARITY_ODD); without it there
// is no parity bit and rx_parity_err is tied low.
module uart_param
   import uart_param_pkg::*;
#(
   parameter int CLK_DIV_W  = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CLK_DIV_W-1:0] baud_div,
   input  logic                 rx,
   output logic                 tx,
   uart_param_if.slave          bus,
   output logic                 is_receiving,
   output logic                 is_transmitting
);

   if (!params_legal(DATA_BITS, STOP_BITS, OVERSAMPLE, PARITY_ODD)) begin : g_bad_params
      $error("uart_param: illegal DATA_BITS/STOP_BITS/OVERSAMPLE/PARITY_ODD");
   end

   localparam int                   OS_W         = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]      OS_LAST      = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]      OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_CNT_W-1:0] DATA_LAST    = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] STOP_LAST    = BIT_CNT_W'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
   localparam logic                 PAR_ODD      = (PARITY_ODD != 0);
`endif

   // ---------------------------------------------------------------- RX ----

   rx_state_t              rx_state;
   logic                   rx_meta;
   logic                   rx_sync;
   logic                   rx_tick;
   logic [OS_W-1:0]        rx_os;
   logic [BIT_CNT_W-1:0]   rx_bits;
   logic [DATA_BITS-1:0]   rx_shreg;
   logic [DATA_BITS-1:0]   rx_data_q;
   logic                   rx_valid_q;
   logic                   rx_ferr_q;
`ifdef UART_PARITY_EN
   logic                   rx_perr_pend;
   logic                   rx_perr_q;
`endif

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clk) begin
      // NOTE: the synchroniser resets to 1 (idle line) so leaving reset can
      // never be mistaken for a start bit.
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   uart_tick_gen #(
      .CLK_DIV_W (CLK_DIV_W)
   ) u_rx_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (rx_state == RX_IDLE),
      .div     (baud_div),
      .tick    (rx_tick)
   );

   // RX FSM: start detection, centre-of-bit sampling and result reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state     <= RX_IDLE;
         rx_os        <= '0;
         rx_bits      <= '0;
         rx_shreg     <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_perr_pend <= 1'b0;
         rx_perr_q    <= 1'b0;
`endif
      end else begin
         rx_valid_q <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_os   <= '0;
               rx_bits <= '0;
               if (!rx_sync) begin
                  rx_state <= RX_START;
               end
            end

            // Wait half a bit, then confirm the start bit is still low.
            RX_START: begin
               if (rx_tick) begin
                  if (rx_os == OS_HALF_LAST) begin
                     rx_os    <= '0;
                     rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_os <= rx_os + 1'b1;
                  end
               end
            end

            // Sample each data bit at its centre, LSB first.
            RX_DATA: begin
               if (rx_tick) begin
                  if (rx_os == OS_LAST) begin
                     rx_os    <= '0;
                     rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                     if (rx_bits == DATA_LAST) begin
                        rx_bits <= '0;
`ifdef UART_PARITY_EN
                        rx_state <= RX_PARITY;
`else
                        rx_state <= RX_STOP;
`endif
                     end else begin
                        rx_bits <= rx_bits + 1'b1;
                     end
                  end else begin
                     rx_os <= rx_os + 1'b1;
                  end
               end
            end

`ifdef UART_PARITY_EN
            // Mismatch when the sampled bit differs from the expected parity.
            RX_PARITY: begin
               if (rx_tick) begin
                  if (rx_os == OS_LAST) begin
                     rx_os        <= '0;
                     rx_perr_pend <= rx_sync ^ (^rx_shreg) ^ PAR_ODD;
                     rx_state     <= RX_STOP;
                  end else begin
                     rx_os <= rx_os + 1'b1;
                  end
               end
            end
`endif

            // Only the first stop bit is checked; a low stop bit is a break.
            RX_STOP: begin
               if (rx_tick) begin
                  if (rx_os == OS_LAST) begin
                     rx_os      <= '0;
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= rx_shreg;
                     rx_ferr_q  <= !rx_sync;
`ifdef UART_PARITY_EN
                     rx_perr_q  <= rx_perr_pend;
`endif
                     rx_state   <= rx_sync ? RX_IDLE : RX_BREAK;
                  end else begin
                     rx_os <= rx_os + 1'b1;
                  end
               end
            end

            // Hold off until the line returns high.
            RX_BREAK: begin
               if (rx_sync) begin
                  rx_state <= RX_IDLE;
               end
            end

            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign bus.rx_data      = rx_data_q;
   assign bus.rx_valid     = rx_valid_q;
   assign bus.rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
   assign bus.rx_parity_err = rx_perr_q;
`else
   assign bus.rx_parity_err = 1'b0;
`endif
   assign is_receiving = (rx_state != RX_IDLE);

   // ---------------------------------------------------------------- TX ----

   tx_state_t              tx_state;
   logic                   tx_q;
   logic                   tx_ready_q;
   logic                   tx_tick;
   logic [OS_W-1:0]        tx_os;
   logic [BIT_CNT_W-1:0]   tx_bits;
   logic [DATA_BITS-1:0]   tx_shreg;
`ifdef UART_PARITY_EN
   logic                   tx_par;
`endif

   uart_tick_gen #(
      .CLK_DIV_W (CLK_DIV_W)
   ) u_tx_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (tx_state == TX_IDLE),
      .div     (baud_div),
      .tick    (tx_tick)
   );

   // TX FSM: accept a character, then shift out start, data, parity, stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b0;
         tx_os      <= '0;
         tx_bits    <= '0;
         tx_shreg   <= '0;
`ifdef UART_PARITY_EN
         tx_par     <= 1'b0;
`endif
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_q       <= 1'b1;
               tx_ready_q <= 1'b1;
               tx_os      <= '0;
               tx_bits    <= '0;
               if (bus.tx_valid && tx_ready_q) begin
                  tx_shreg   <= bus.tx_data;
`ifdef UART_PARITY_EN
                  tx_par     <= (^bus.tx_data) ^ PAR_ODD;
`endif
                  tx_q       <= 1'b0;
                  tx_ready_q <= 1'b0;
                  tx_state   <= TX_START;
               end
            end

            TX_START: begin
               if (tx_tick) begin
                  if (tx_os == OS_LAST) begin
                     tx_os    <= '0;
                     tx_q     <= tx_shreg[0];
                     tx_shreg <= tx_shreg >> 1;
                     tx_state <= TX_DATA;
                  end else begin
                     tx_os <= tx_os + 1'b1;
                  end
               end
            end

            TX_DATA: begin
               if (tx_tick) begin
                  if (tx_os == OS_LAST) begin
                     tx_os <= '0;
                     if (tx_bits == DATA_LAST) begin
                        tx_bits <= '0;
`ifdef UART_PARITY_EN
                        tx_q     <= tx_par;
                        tx_state <= TX_PARITY;
`else
                        tx_q     <= 1'b1;
                        tx_state <= TX_STOP;
`endif
                     end else begin
                        tx_bits  <= tx_bits + 1'b1;
                        tx_q     <= tx_shreg[0];
                        tx_shreg <= tx_shreg >> 1;
                     end
                  end else begin
                     tx_os <= tx_os + 1'b1;
                  end
               end
            end

`ifdef UART_PARITY_EN
            TX_PARITY: begin
               if (tx_tick) begin
                  if (tx_os == OS_LAST) begin
                     tx_os    <= '0;
                     tx_q     <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_os <= tx_os + 1'b1;
                  end
               end
            end
`endif

            // Ready rises as the final stop bit ends, so the next character
            // can be accepted on the very next edge.
            TX_STOP: begin
               if (tx_tick) begin
                  if (tx_os == OS_LAST) begin
                     tx_os <= '0;
                     if (tx_bits == STOP_LAST) begin
                        tx_bits    <= '0;
                        tx_ready_q <= 1'b1;
                        tx_state   <= TX_IDLE;
                     end else begin
                        tx_bits <= tx_bits + 1'b1;
                     end
                  end else begin
                     tx_os <= tx_os + 1'b1;
                  end
               end
            end

            default: begin
               tx_q     <= 1'b1;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   assign tx              = tx_q;
   assign bus.tx_ready    = tx_ready_q;
   assign is_transmitting = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: self-checking bench for uart_param (DATA_BITS=8, 1 stop
// bit, OVERSAMPLE=16). The expected serial waveform and received characters
// come from a frame model built from the character's bits; builds with and
// without UART_PARITY_EN are both handled.
module tb_uart_param;

   localparam int DB   = 8;
   localparam int SB   = 1;
   localparam int OS   = 16;
   localparam int PODD = 0;
`ifdef UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef logic bit_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] baud_div = '0;
   logic        rx_drv = 1'b1;
   logic        loopback = 1'b0;
   logic        rx_line;
   logic        tx;
   logic        is_receiving;
   logic        is_transmitting;

   int n_checks = 0;
   int n_pass   = 0;

   logic [9:0] rx_q[$];   // observed {parity_err, frame_err, data}
   logic [9:0] exp_q[$];  // expected {parity_err, frame_err, data}

   uart_param_if #(.DATA_BITS(DB)) bus ();

   assign rx_line = loopback ? tx : rx_drv;

   uart_param #(
      .CLK_DIV_W  (16),
      .DATA_BITS  (DB),
      .STOP_BITS  (SB),
      .OVERSAMPLE (OS),
      .PARITY_ODD (PODD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .baud_div        (baud_div),
      .rx              (rx_line),
      .tx              (tx),
      .bus             (bus),
      .is_receiving    (is_receiving),
      .is_transmitting (is_transmitting)
   );

   always #5 clk = ~clk;

   // Collect every cycle in which rx_valid is high.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.rx_valid === 1'b1)
         rx_q.push_back({bus.rx_parity_err, bus.rx_frame_err, bus.rx_data});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Parity of a character from its count of ones.
   function automatic logic model_parity(input logic [7:0] d);
      logic even_par;
      even_par = logic'($countones(d) % 2);
      return (PODD != 0) ? !even_par : even_par;
   endfunction

   // Line levels of one frame: start, data LSB first, optional parity, stops.
   function automatic void build_frame(input logic [7:0] d, input logic par,
                                       input logic stop, input int n_stop,
                                       output bit_q_t bits);
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(d[i]);
      if (PAR_EN) bits.push_back(par);
      for (int i = 0; i < n_stop; i++) bits.push_back(stop);
   endfunction

   task automatic send_char(input logic [7:0] d);
      int n;
      n = 0;
      while (bus.tx_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready before send", bus.tx_ready, 1);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
   endtask

   // Called on the first cycle after acceptance; compares every cycle of tx.
   task automatic check_tx_frame(input string name, input logic [7:0] d);
      bit_q_t bits;
      int     bt;
      int     match;
      logic   busy_ready;
      build_frame(d, model_parity(d), 1'b1, SB, bits);
      bt = OS * (int'(baud_div) + 1);
      busy_ready = 1'bx;
      for (int b = 0; b < bits.size(); b++) begin
         match = 0;
         for (int c = 0; c < bt; c++) begin
            if (tx === bits[b]) match++;
            if (b == bits.size() - 1 && c == bt - 1) busy_ready = bus.tx_ready;
            @(negedge clk);
         end
         check($sformatf("%s tx bit %0d cycles", name, b), match, bt);
      end
      check({name, " tx_ready low in last cycle"}, busy_ready, 0);
      check({name, " tx_ready high after frame"}, bus.tx_ready, 1);
   endtask

   task automatic drive_bits(input bit_q_t bits);
      for (int b = 0; b < bits.size(); b++) begin
         rx_drv = bits[b];
         repeat (OS * (int'(baud_div) + 1)) @(negedge clk);
      end
   endtask

   task automatic drain_rx(input string name);
      int n;
      check({name, " rx_valid count"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s rx char %0d {perr,ferr,data}", name, i), rx_q[i], exp_q[i]);
      rx_q  = {};
      exp_q = {};
   endtask

   task automatic loop_char(input string name, input logic [7:0] d);
      send_char(d);
      exp_q.push_back({1'b0, 1'b0, d});
      check_tx_frame(name, d);
   endtask

   initial begin
      bit_q_t bits;
      logic [7:0] d;
      logic saw_rx;

      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      check("reset tx", tx, 1);
      check("reset tx_ready", bus.tx_ready, 0);
      check("reset rx_data", bus.rx_data, 0);
      check("reset rx_valid", bus.rx_valid, 0);
      check("reset errs", {bus.rx_frame_err, bus.rx_parity_err}, 0);
      check("reset busy", {is_receiving, is_transmitting}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("tx_ready after reset", bus.tx_ready, 1);

      // 0xA5 waveform at baud_div=0.
      send_char(8'hA5);
      check_tx_frame("A5", 8'hA5);
      repeat (20) @(negedge clk);
      rx_q = {};

      // Back-to-back loopback characters.
      loopback = 1'b1;
      repeat (5) @(negedge clk);
      loop_char("b2b 00", 8'h00);
      loop_char("b2b FF", 8'hFF);
      loop_char("b2b 3C", 8'h3C);
      repeat (40) @(negedge clk);
      drain_rx("b2b");

      // Random characters with random divisors, changed only while idle.
      for (int i = 0; i < 8; i++) begin
         baud_div = 16'($urandom_range(0, 2));
         repeat (3) @(negedge clk);
         d = 8'($urandom);
         loop_char($sformatf("rand%0d", i), d);
         repeat (40) @(negedge clk);
         drain_rx($sformatf("rand%0d", i));
      end
      baud_div = '0;

      // Short low glitch on rx.
      loopback = 1'b0;
      rx_drv   = 1'b1;
      repeat (10) @(negedge clk);
      saw_rx = 1'b0;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (is_receiving) saw_rx = 1'b1;
         @(negedge clk);
      end
      check("glitch seen by rx", saw_rx, 1);
      check("glitch is_receiving back to 0", is_receiving, 0);
      drain_rx("glitch");

      // Stop bit low followed by a long break.
      d = 8'($urandom);
      build_frame(d, model_parity(d), 1'b0, 1, bits);
      drive_bits(bits);
      rx_drv = 1'b0;
      repeat (20 * OS) @(negedge clk);
      check("break one pulse", rx_q.size(), 1);
      check("break holds is_receiving", is_receiving, 1);
      rx_drv = 1'b1;
      repeat (10) @(negedge clk);
      check("break released", is_receiving, 0);
      exp_q.push_back({1'b0, 1'b1, d});
      drain_rx("break");

`ifdef UART_PARITY_EN
      // Parity: 0x07 with a wrong parity bit, then a random correct frame.
      build_frame(8'h07, 1'b0, 1'b1, 1, bits);
      drive_bits(bits);
      repeat (20) @(negedge clk);
      exp_q.push_back({1'b1, 1'b0, 8'h07});
      drain_rx("bad parity");
      d = 8'($urandom);
      build_frame(d, model_parity(d), 1'b1, 1, bits);
      drive_bits(bits);
      repeat (20) @(negedge clk);
      exp_q.push_back({1'b0, 1'b0, d});
      drain_rx("good parity");
`endif

      // Reset in the middle of a loopback frame.
      loopback = 1'b1;
      repeat (5) @(negedge clk);
      send_char(8'h5A);
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid reset tx", tx, 1);
      check("mid reset tx_ready", bus.tx_ready, 0);
      check("mid reset busy", {is_receiving, is_transmitting}, 0);
      repeat (2) @(negedge clk);
      check("mid reset tx_ready held", bus.tx_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("tx_ready after mid reset", bus.tx_ready, 1);
      check("rx_data after mid reset", bus.rx_data, 0);
      repeat (200) @(negedge clk);
      drain_rx("aborted frame");
      loop_char("post reset 55", 8'h55);
      repeat (40) @(negedge clk);
      drain_rx("post reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
